// File: rtl/mac_pe_ws_if.sv
// ---------------------------------------------------------------------------
// mac_pe_ws_if
// Groups the per-PE bus of the weight-stationary MAC processing element:
// the weight daisy chain, the swap strobe, the west->east activation path,
// the north->south partial-sum path and the sticky overflow flag.
//
// Modports
//   slave  : PE view. It receives weight/activation/psum/control and drives
//            the registered east/south outputs and ovf.
//   master : Driver view, which is the array edge or a neighbouring PE.
//
// Signals
//   weight_in, weight_load_in    weight data and load strobe into the PE
//   weight_out, weight_load_out  registered copies for the next PE down
//   weight_swap                  copy shadow weight into active weight
//   act_in, act_valid_in         activation and valid from the west
//   act_out, act_valid_out       registered activation and valid
//   psum_in / psum_out           partial sum from the north / to the south
//   ovf_clr / ovf                sticky overflow clear / flag
// ---------------------------------------------------------------------------
interface mac_pe_ws_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] weight_in;
  logic                  weight_load_in;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  weight_load_out;
  logic                  weight_swap;
  logic [DATA_WIDTH-1:0] act_in;
  logic                  act_valid_in;
  logic [DATA_WIDTH-1:0] act_out;
  logic                  act_valid_out;
  logic [ACC_WIDTH-1:0]  psum_in;
  logic [ACC_WIDTH-1:0]  psum_out;
  logic                  ovf_clr;
  logic                  ovf;

  modport slave (
    input  weight_in, weight_load_in, weight_swap,
    input  act_in, act_valid_in, psum_in, ovf_clr,
    output weight_out, weight_load_out, act_out, act_valid_out,
    output psum_out, ovf
  );

  modport master (
    output weight_in, weight_load_in, weight_swap,
    output act_in, act_valid_in, psum_in, ovf_clr,
    input  weight_out, weight_load_out, act_out, act_valid_out,
    input  psum_out, ovf
  );
endinterface

// File: rtl/mac_pe_ws.sv
// ---------------------------------------------------------------------------
// mac_pe_ws
// Weight-stationary systolic MAC processing element. It has two weight
// registers: the shadow register fills from the weight daisy chain while
// the active register supplies the weight for the current tile.
// Every valid cycle computes
//   psum_out <= f(psum_in + act_in * active_w)
// with one cycle of latency. All east/south outputs are registered, so
// PEs tile directly into an R x C array.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset. It clears every register,
//        including the data registers.
//   pe   mac_pe_ws_if.slave bus; see mac_pe_ws_if.sv for its signals.
//
// Build option
//   PE_SATURATE_EN  When defined, an overflowing sum clamps to the ACC_WIDTH
//                   signed limits. When undefined, the sum wraps and keeps
//                   its low ACC_WIDTH bits. ovf behaves the same either way.
// ---------------------------------------------------------------------------
module mac_pe_ws #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  mac_pe_ws_if.slave     pe
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
    $error("mac_pe_ws: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  logic signed [DATA_WIDTH-1:0] r_shadow_w;
  logic signed [DATA_WIDTH-1:0] r_active_w;
  logic        [DATA_WIDTH-1:0] r_weight_p1;
  logic                         r_wload_p1;
  logic        [DATA_WIDTH-1:0] r_act_p1;
  logic                         r_vld_p1;
  logic signed [ACC_WIDTH-1:0]  r_psum_p1;
  logic                         r_ovf;

  logic signed [DATA_WIDTH-1:0] w_act;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic                         w_sum_ovf;
  logic signed [ACC_WIDTH-1:0]  w_psum_nxt;

`ifdef PE_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Clamp an (ACC_WIDTH+1)-bit sum into ACC_WIDTH bits. The extra top bit
  // is the true sign and selects which limit to use.
  function automatic logic signed [ACC_WIDTH-1:0] sat_sum(
    input logic signed [ACC_WIDTH:0] s
  );
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      sat_sum = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else
      sat_sum = s[ACC_WIDTH-1:0];
  endfunction
`endif

  // Multiply-add, computed combinationally ahead of the output registers.
  // The product is sign-extended and then added at ACC_WIDTH+1 bits, so the
  // result never loses its true sign.
  assign w_act  = pe.act_in;
  assign w_prod = w_act * r_active_w;
  assign w_sum  = $signed({pe.psum_in[ACC_WIDTH-1], pe.psum_in})
                + $signed({{(ACC_WIDTH+1-PROD_W){w_prod[PROD_W-1]}}, w_prod});
  assign w_sum_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

`ifdef PE_SATURATE_EN
  assign w_psum_nxt = sat_sum(w_sum);
`else
  assign w_psum_nxt = w_sum[ACC_WIDTH-1:0];
`endif

  // ---- stage p0 -> p1 : weight chain, swap, MAC result, overflow ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_w  <= '0;
      r_active_w  <= '0;
      r_weight_p1 <= '0;
      r_wload_p1  <= 1'b0;
      r_act_p1    <= '0;
      r_vld_p1    <= 1'b0;
      r_psum_p1   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_weight_p1 <= pe.weight_in;
      r_wload_p1  <= pe.weight_load_in;
      if (pe.weight_load_in)
        r_shadow_w <= pe.weight_in;
      // The swap takes the pre-edge shadow value. A load in the same cycle
      // therefore goes to the next tile, and the product this cycle still
      // uses the old active weight.
      if (pe.weight_swap)
        r_active_w <= r_shadow_w;
      r_vld_p1 <= pe.act_valid_in;
      // Bubbles leave the data lines untouched.
      if (pe.act_valid_in) begin
        r_act_p1  <= pe.act_in;
        r_psum_p1 <= w_psum_nxt;
      end
      // A set takes priority over a clear in the same cycle.
      if (pe.act_valid_in && w_sum_ovf)
        r_ovf <= 1'b1;
      else if (pe.ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign pe.weight_out      = r_weight_p1;
  assign pe.weight_load_out = r_wload_p1;
  assign pe.act_out         = r_act_p1;
  assign pe.act_valid_out   = r_vld_p1;
  assign pe.psum_out        = r_psum_p1;
  assign pe.ovf             = r_ovf;

endmodule

// File: tb/tb_mac_pe_ws.sv
module tb_mac_pe_ws;

  localparam int DW = 4;
  localparam int AW = 16;

`ifdef PE_SATURATE_EN
  localparam logic [AW-1:0] POS_OVF_PSUM = 16'h7FFF;
  localparam logic [AW-1:0] NEG_OVF_PSUM = 16'h8000;
`else
  localparam logic [AW-1:0] POS_OVF_PSUM = 16'h8030;
  localparam logic [AW-1:0] NEG_OVF_PSUM = 16'h7FC8;
`endif

  typedef struct {
    logic [DW-1:0] act;
    logic [AW-1:0] psum;
    logic          ovf;
    string         tag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  bit   stim_done;
  exp_t exp_q[$];

  mac_pe_ws_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) pe_if ();

  mac_pe_ws #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .pe  (pe_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then return #1 after the capturing edge.
  task automatic drive(input logic [DW-1:0] wi, input logic wl, input logic sw,
                       input logic [DW-1:0] a, input logic v,
                       input logic [AW-1:0] p, input logic clr);
    pe_if.weight_in      = wi;
    pe_if.weight_load_in = wl;
    pe_if.weight_swap    = sw;
    pe_if.act_in         = a;
    pe_if.act_valid_in   = v;
    pe_if.psum_in        = p;
    pe_if.ovf_clr        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive('0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic expect_out(input logic [DW-1:0] a, input logic [AW-1:0] p,
                            input logic o, input string tag);
    exp_t e;
    e.act = a; e.psum = p; e.ovf = o; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: consume one expectation per valid output.
  always @(negedge clk) begin
    if (!rst && pe_if.act_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_valid: psum_out=%0h with empty queue", pe_if.psum_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_psum"}, 32'(pe_if.psum_out), 32'(e.psum));
        check({e.tag, "_act"},  32'(pe_if.act_out),  32'(e.act));
        check({e.tag, "_ovf"},  32'(pe_if.ovf),      32'(e.ovf));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    stim_done = 1'b0;
    rst = 1'b1;
    pe_if.weight_in = '0; pe_if.weight_load_in = 1'b0; pe_if.weight_swap = 1'b0;
    pe_if.act_in = '0; pe_if.act_valid_in = 1'b0; pe_if.psum_in = '0; pe_if.ovf_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_psum",  32'(pe_if.psum_out),        32'h0);
    check("rst_act",   32'(pe_if.act_out),         32'h0);
    check("rst_vld",   32'(pe_if.act_valid_out),   32'h0);
    check("rst_ovf",   32'(pe_if.ovf),             32'h0);
    check("rst_wout",  32'(pe_if.weight_out),      32'h0);
    check("rst_wlout", 32'(pe_if.weight_load_out), 32'h0);
    rst = 1'b0;

    // 1: load 3, swap, then -2*3 + 10 = 4
    drive(4'd3, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive('0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0);
    expect_out(4'hE, 16'd4, 1'b0, "t1_basic");
    drive('0, 1'b0, 1'b0, 4'hE, 1'b1, 16'd10, 1'b0);
    idle();

    // 2: chain passes weight 5 one cycle later; active stays 3 until swap
    drive(4'd5, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check("t2_wout",  32'(pe_if.weight_out),      32'h5);
    check("t2_wlout", 32'(pe_if.weight_load_out), 32'h1);
    idle();
    check("t2_wlout_drop", 32'(pe_if.weight_load_out), 32'h0);
    expect_out(4'd1, 16'd3, 1'b0, "t2_active_kept");
    drive('0, 1'b0, 1'b0, 4'd1, 1'b1, 16'd0, 1'b0);

    // 3: shadow=2, then load 7 + swap + valid in the same cycle
    drive(4'd2, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    expect_out(4'd1, 16'd3, 1'b0, "t3_old_active");
    drive(4'd7, 1'b1, 1'b1, 4'd1, 1'b1, 16'd0, 1'b0);
    expect_out(4'd1, 16'd2, 1'b0, "t3_swapped");
    drive('0, 1'b0, 1'b0, 4'd1, 1'b1, 16'd0, 1'b0);
    drive('0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0);
    expect_out(4'd1, 16'd7, 1'b0, "t3_second_swap");
    drive('0, 1'b0, 1'b0, 4'd1, 1'b1, 16'd0, 1'b0);

    // 4: positive overflow 32767 + 49; then clear; then clear vs. set
    expect_out(4'd7, POS_OVF_PSUM, 1'b1, "t4_pos_ovf");
    drive('0, 1'b0, 1'b0, 4'd7, 1'b1, 16'h7FFF, 1'b0);
    drive('0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    check("t4_ovf_clr", 32'(pe_if.ovf), 32'h0);
    expect_out(4'd7, POS_OVF_PSUM, 1'b1, "t4_set_wins");
    drive('0, 1'b0, 1'b0, 4'd7, 1'b1, 16'h7FFF, 1'b1);
    drive('0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

    // 5: negative overflow -32768 + (-8*7)
    drive(4'h8, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    drive('0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0);
    expect_out(4'd7, NEG_OVF_PSUM, 1'b1, "t5_neg_ovf");
    drive('0, 1'b0, 1'b0, 4'd7, 1'b1, 16'h8000, 1'b0);
    drive('0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

    // 6: 100 + 3*(-8) = 76, then three bubbles hold the data lines
    expect_out(4'd3, 16'd76, 1'b0, "t6_pre_bubble");
    drive('0, 1'b0, 1'b0, 4'd3, 1'b1, 16'd100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b0, 1'b0, 4'd9, 1'b0, 16'd1234, 1'b0);
      check("t6_bubble_vld",  32'(pe_if.act_valid_out), 32'h0);
      check("t6_bubble_psum", 32'(pe_if.psum_out),      32'd76);
      check("t6_bubble_act",  32'(pe_if.act_out),       32'd3);
    end
    // reset together with a valid input discards that input
    rst = 1'b1;
    drive(4'd6, 1'b1, 1'b1, 4'd5, 1'b1, 16'd5, 1'b0);
    rst = 1'b0;
    check("t6_rst_psum", 32'(pe_if.psum_out),        32'h0);
    check("t6_rst_act",  32'(pe_if.act_out),         32'h0);
    check("t6_rst_vld",  32'(pe_if.act_valid_out),   32'h0);
    check("t6_rst_ovf",  32'(pe_if.ovf),             32'h0);
    check("t6_rst_wout", 32'(pe_if.weight_out),      32'h0);
    check("t6_rst_wl",   32'(pe_if.weight_load_out), 32'h0);
    // active weight was cleared by reset: 9 + 5*0 = 9
    expect_out(4'd5, 16'd9, 1'b0, "t6_after_rst");
    drive('0, 1'b0, 1'b0, 4'd5, 1'b1, 16'd9, 1'b0);
    idle();
    idle();
    stim_done = 1'b1;
  end

  initial begin
    fork
      wait (stim_done);
      begin
        repeat (2000) @(posedge clk);
        n_checks++;
        n_fails++;
        $display("FAIL timeout: stimulus not complete after %0d cycles, expected completion", 2000);
      end
    join_any
    disable fork;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mac_pe_ws.md
Name: mac_pe_ws

Overview:
Parametrised weight-stationary systolic processing element. It is the successor to the single-register int4 MAC cell.
- Double-buffered weights: shadow register plus active register, so the next tile's weights stream in while the current tile computes.
- Signed multiply-add of a west-flowing activation against the active weight, added to a north-supplied partial sum.
- Registered activation, partial-sum and weight-chain outputs, so PEs tile directly into an R x C array.
- Sticky overflow flag.

Parameters:
DATA_WIDTH, 4, activation/weight width (signed two's complement).
ACC_WIDTH, 16, partial-sum width. Must be >= 2*DATA_WIDTH; an elaboration-time check fails otherwise.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
weight_in  in  DATA_WIDTH  weight data from the PE above, or from the array edge
weight_load_in  in  1  capture weight_in into the shadow register
weight_out  out  DATA_WIDTH  registered weight_in, for daisy-chain loading
weight_load_out  out  1  registered weight_load_in
weight_swap  in  1  copy shadow into active
act_in  in  DATA_WIDTH  activation from the west
act_valid_in  in  1  act_in and psum_in valid this cycle
act_out  out  DATA_WIDTH  registered activation to the east
act_valid_out  out  1  registered valid to the east/south
psum_in  in  ACC_WIDTH  partial sum from the north
psum_out  out  ACC_WIDTH  registered partial sum to the south
ovf_clr  in  1  clear the sticky overflow flag
ovf  out  1  sticky overflow flag

Behaviour:
- Reset: shadow_w, active_w, weight_out, act_out and psum_out go to 0. weight_load_out, act_valid_out and ovf go to 0. Reset overrides every other input in the same cycle. Reset mid-tile discards in-flight data with no partial output.
- Weight chain, every cycle:
  - weight_out <= weight_in and weight_load_out <= weight_load_in, unconditionally.
  - If weight_load_in, shadow_w <= weight_in.
- Swap: if weight_swap, active_w <= shadow_w (the pre-edge value).
  - Load and swap in the same cycle: active_w gets the old shadow; shadow_w gets the new weight_in.
  - Swap in the same cycle as act_valid_in: the product uses the old active_w. The new weight applies from the next cycle.
- Compute, latency 1 cycle:
  - If act_valid_in: act_out <= act_in, act_valid_out <= 1, psum_out <= f(psum_in + sext(act_in) * sext(active_w)).
  - Else: act_valid_out <= 0, and act_out and psum_out hold their previous values (bubbles do not corrupt the data lines).
- Arithmetic:
  - Product is signed, 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
  - The sum is formed at ACC_WIDTH+1 bits.
  - Signed overflow means the sum lies outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - f() is defined under Optional Feature.
- Overflow flag:
  - ovf <= 1 on any valid cycle whose sum overflows.
  - Otherwise, if ovf_clr, ovf <= 0. A set in the same cycle wins over ovf_clr.
  - ovf holds until rst or ovf_clr.
- No internal state machine beyond the registers above. Throughput is one MAC per cycle with no back-pressure; downstream must accept every valid cycle.

Optional Feature:
Macro PE_SATURATE_EN.
- Defined: f() clamps an overflowing sum to 2^(ACC_WIDTH-1)-1 on positive overflow, or -2^(ACC_WIDTH-1) on negative overflow.
- Undefined: f() keeps the low ACC_WIDTH bits (two's-complement wrap).
- ovf behaves identically in both builds.

Test Plan:
1. Reset, then weight_in=3 with weight_load_in=1; next cycle weight_swap=1; then act_in=-2 (4'hE), psum_in=10, valid=1 -> next cycle psum_out=4, act_out=4'hE, act_valid_out=1, ovf=0.
2. Chain: weight_load_in pulse with weight_in=5 -> weight_out=5 and weight_load_out=1 exactly one cycle later. active_w stays unchanged until swap.
3. Same-cycle load(7) + swap while shadow=2 and valid act_in=1, psum_in=0 -> psum_out=old active. Next valid act_in=1 -> psum_out=2. A further swap -> product uses 7.
4. Overflow: active_w=7, act_in=7, psum_in=32767, valid -> ovf=1. psum_out=16'h8030 without PE_SATURATE_EN, 16'h7FFF with it. Then ovf_clr=1 with no overflow -> ovf=0. ovf_clr coincident with a new overflow -> ovf stays 1.
5. Negative saturation: active_w=-8, act_in=7, psum_in=-32768 -> psum_out=16'h8000 with the macro, 16'h7FC8 without; ovf=1.
6. Bubble/reset: valid, then act_valid_in=0 for 3 cycles -> act_valid_out=0 and psum_out/act_out held. Assert rst mid-stream together with valid=1 -> all outputs 0 on the next cycle; no accumulation from that cycle.
